// File: rtl/ddr_pkg.sv
// ddr_pkg: shared DDR4 controller timing constants and types.
//
// Contents:
//   - Core timing defaults (CK_t cycles): tRC, tMOD, tREFI, tRP, tRFC,
//     plus REF_ALMOST_WIN, the early-warning window before a refresh falls due.
//   - Refresh debt sizing, selected by the macro REF_POSTPONE_EN:
//       defined   -> up to 8 postponed refreshes, 4-bit debt counter,
//                    each refresh sequence drains the whole debt.
//       undefined -> at most 1 owed refresh, 1-bit debt counter,
//                    exactly one REF per sequence.
//   - ref_state_type: refresh sequencer states.
package ddr_pkg;

  localparam int tRC            = 45;
  localparam int tMOD           = 24;
  localparam int tREFI          = 6240;
  localparam int tRP            = 11;
  localparam int tRFC           = 280;
  localparam int REF_ALMOST_WIN = 64;

`ifdef REF_POSTPONE_EN
  localparam bit POSTPONE_EN = 1'b1;
  localparam int MAX_DEBT    = 8;
  localparam int PEND_W      = 4;
`else
  localparam bit POSTPONE_EN = 1'b0;
  localparam int MAX_DEBT    = 1;
  localparam int PEND_W      = 1;
`endif

  typedef enum logic [2:0] {
    RF_IDLE = 3'd0,
    RF_PREA = 3'd1,
    RF_TRP  = 3'd2,
    RF_REF  = 3'd3,
    RF_TRFC = 3'd4,
    RF_DONE = 3'd5
  } ref_state_type;

endpackage

// File: rtl/ref_interval_cnt.sv
// ref_interval_cnt: tREFI interval timer and refresh-debt bookkeeping.
//
// Ports:
//   CK_t           in   controller clock
//   reset_n        in   asynchronous active-low reset
//   ref_accept     in   a REF command was accepted by the arbiter this cycle
//   pending        out  number of refreshes currently owed
//   refresh_almost out  registered: debt outstanding or interval end is near
//   refresh_err    out  sticky: an interval elapsed with the debt already full
//
// The debt limit comes from ddr_pkg (macro REF_POSTPONE_EN).
module ref_interval_cnt
  import ddr_pkg::*;
#(
  parameter int TREFI      = tREFI,
  parameter int ALMOST_WIN = REF_ALMOST_WIN
) (
  input  logic              CK_t,
  input  logic              reset_n,
  input  logic              ref_accept,
  output logic [PEND_W-1:0] pending,
  output logic              refresh_almost,
  output logic              refresh_err
);

  localparam int                ICNT_W    = $clog2(TREFI);
  localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(TREFI - 1);
  localparam logic [ICNT_W-1:0] ALMOST_AT = ICNT_W'(TREFI - ALMOST_WIN);
  localparam logic [PEND_W-1:0] DEBT_MAX  = PEND_W'(MAX_DEBT);

  logic [ICNT_W-1:0] icnt_q, icnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              almost_q, almost_d;
  logic              err_q, err_d;
  logic              wrap;

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves it unassigned and no latch can be inferred.
  always_comb begin
    wrap      = (icnt_q == ICNT_LAST);
    icnt_d    = icnt_q + ICNT_W'(1);
    pending_d = pending_q;
    err_d     = err_q;
    almost_d  = (pending_q != '0) || (icnt_q >= ALMOST_AT);

    if (wrap) begin
      icnt_d = '0;
      // A REF landing on the wrap cycle pays for the interval just ending.
      if (!ref_accept) begin
        if (pending_q == DEBT_MAX) err_d = 1'b1;
        else                       pending_d = pending_q + PEND_W'(1);
      end
    end else if (ref_accept) begin
      if (pending_q != '0) pending_d = pending_q - PEND_W'(1);
      else                 icnt_d    = '0;  // pulled-in refresh restarts the interval
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, matching real hardware.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      icnt_q    <= '0;
      pending_q <= '0;
      almost_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      icnt_q    <= icnt_d;
      pending_q <= pending_d;
      almost_q  <= almost_d;
      err_q     <= err_d;
    end
  end

  assign pending        = pending_q;
  assign refresh_almost = almost_q;
  assign refresh_err    = err_q;

endmodule

// File: rtl/refresh_sched.sv
// refresh_sched: DDR4 refresh scheduler feeding the controller FSM.
//
// Tracks the tREFI interval and the owed-refresh debt (ref_interval_cnt) and,
// when the controller enters its refresh state, runs PREA -> tRP -> REF -> tRFC.
// With macro REF_POSTPONE_EN defined, the sequence keeps issuing REFs until
// the debt is drained; otherwise it issues exactly one REF.
//
// Ports:
//   CK_t           in   controller clock
//   reset_n        in   asynchronous active-low reset
//   clear_refresh  in   holds the sequencer idle / releases refresh_done
//   refresh_start  in   controller FSM is in its refresh state
//   cmd_ready      in   arbiter accepts cmd_* this cycle
//   cmd_valid      out  command request
//   cmd_is_ref     out  0 = PREA, 1 = REF (meaningful with cmd_valid)
//   refresh_almost out  refresh owed or imminent
//   refresh_done   out  sequence complete, held until clear_refresh
//   refresh_err    out  sticky debt overflow
module refresh_sched
  import ddr_pkg::*;
#(
  parameter int TREFI      = tREFI,
  parameter int TRP        = tRP,
  parameter int TRFC       = tRFC,
  parameter int ALMOST_WIN = REF_ALMOST_WIN
) (
  input  logic CK_t,
  input  logic reset_n,
  input  logic clear_refresh,
  input  logic refresh_start,
  input  logic cmd_ready,
  output logic cmd_valid,
  output logic cmd_is_ref,
  output logic refresh_almost,
  output logic refresh_done,
  output logic refresh_err
);

  localparam int WAIT_MAX = (TRFC > TRP) ? TRFC : TRP;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  ref_state_type     state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [PEND_W-1:0] pending;
  logic              ref_accept;
  logic              more_refs;

  // Outputs decode straight from the state flop, so the command stays stable
  // under backpressure and everything drops the instant reset asserts.
  assign cmd_valid    = (state_q == RF_PREA) || (state_q == RF_REF);
  assign cmd_is_ref   = (state_q == RF_REF);
  assign refresh_done = (state_q == RF_DONE);
  assign ref_accept   = cmd_valid & cmd_ready & cmd_is_ref;
  assign more_refs    = POSTPONE_EN && (pending != '0);

  ref_interval_cnt #(
    .TREFI      (TREFI),
    .ALMOST_WIN (ALMOST_WIN)
  ) u_cnt (
    .CK_t           (CK_t),
    .reset_n        (reset_n),
    .ref_accept     (ref_accept),
    .pending        (pending),
    .refresh_almost (refresh_almost),
    .refresh_err    (refresh_err)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    // clear_refresh both releases RF_DONE and aborts any sequence in flight.
    if (clear_refresh) begin
      state_d = RF_IDLE;
    end else begin
      case (state_q)
        RF_IDLE: if (refresh_start) state_d = RF_PREA;
        RF_PREA: if (cmd_ready) begin
          wcnt_d  = WAIT_W'(TRP - 1);
          state_d = RF_TRP;
        end
        RF_TRP: begin
          if (wcnt_q == '0) state_d = RF_REF;
          else              wcnt_d  = wcnt_q - WAIT_W'(1);
        end
        RF_REF: if (cmd_ready) begin
          wcnt_d  = WAIT_W'(TRFC - 1);
          state_d = RF_TRFC;
        end
        RF_TRFC: begin
          if (wcnt_q == '0) state_d = more_refs ? RF_REF : RF_DONE;
          else              wcnt_d  = wcnt_q - WAIT_W'(1);
        end
        RF_DONE: state_d = RF_DONE;
        default: state_d = RF_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RF_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_refresh_sched.sv
// tb_refresh_sched: self-checking bench for refresh_sched.
// A cycle-indexed behavioural model (interval/debt arithmetic plus a
// timestamp-based view of the command sequence) is compared against the DUT
// outputs on every falling edge; directed phases add literal expectations.
module tb_refresh_sched;
  import ddr_pkg::*;

  localparam int TREFI      = tREFI;
  localparam int TRP        = tRP;
  localparam int TRFC       = tRFC;
  localparam int ALMOST_WIN = REF_ALMOST_WIN;

  logic CK_t = 1'b0;
  logic reset_n;
  logic clear_refresh, refresh_start, cmd_ready;
  logic cmd_valid, cmd_is_ref, refresh_almost, refresh_done, refresh_err;

  refresh_sched #(
    .TREFI(TREFI), .TRP(TRP), .TRFC(TRFC), .ALMOST_WIN(ALMOST_WIN)
  ) dut (
    .CK_t           (CK_t),
    .reset_n        (reset_n),
    .clear_refresh  (clear_refresh),
    .refresh_start  (refresh_start),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_is_ref     (cmd_is_ref),
    .refresh_almost (refresh_almost),
    .refresh_done   (refresh_done),
    .refresh_err    (refresh_err)
  );

  always #5 CK_t = ~CK_t;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  int cyc;                 // index of the current cycle since reset release
  int m_icnt, m_pending;
  bit m_err, m_almost, m_done;
  int m_cmd;               // 0 none, 1 PREA requested, 2 REF requested
  int m_wake;              // cycle in which the current wait ends (-1: none)
  bit m_wake_ref;          // wait ends in a REF request (else: resolve)

  always @(posedge CK_t or negedge reset_n) begin
    bit acc_prea, acc_ref, wrap;
    int old_pend;
    if (!reset_n) begin
      cyc = 0; m_icnt = 0; m_pending = 0; m_err = 0; m_almost = 0;
      m_done = 0; m_cmd = 0; m_wake = -1; m_wake_ref = 0;
    end else begin
      acc_prea = (m_cmd == 1) && cmd_ready;
      acc_ref  = (m_cmd == 2) && cmd_ready;
      wrap     = (m_icnt == TREFI - 1);
      old_pend = m_pending;
      m_almost = (m_pending != 0) || (m_icnt >= TREFI - ALMOST_WIN);
      if (wrap && acc_ref) m_icnt = 0;
      else if (wrap) begin
        m_icnt = 0;
        if (m_pending == MAX_DEBT) m_err = 1; else m_pending++;
      end else if (acc_ref && m_pending > 0) begin m_pending--; m_icnt++; end
      else if (acc_ref) m_icnt = 0;
      else m_icnt++;

      if (clear_refresh) begin m_cmd = 0; m_done = 0; m_wake = -1; end
      else if (m_done) ;
      else if (acc_prea) begin m_cmd = 0; m_wake = cyc + TRP + 1;  m_wake_ref = 1; end
      else if (acc_ref)  begin m_cmd = 0; m_wake = cyc + TRFC + 1; m_wake_ref = 0; end
      else if (m_wake == cyc + 1) begin
        m_wake = -1;
        if (m_wake_ref || (POSTPONE_EN && old_pend > 0)) m_cmd = 2;
        else m_done = 1;
      end else if (m_cmd == 0 && m_wake < 0 && refresh_start) m_cmd = 1;
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Continuous compare: {valid, is_ref (masked), almost, done, err}.
  always @(negedge CK_t) begin
    check("outputs",
          {27'b0, cmd_valid, cmd_valid & cmd_is_ref, refresh_almost, refresh_done, refresh_err},
          {27'b0, m_cmd != 0, m_cmd == 2, m_almost, m_done, m_err});
  end

  task automatic step();
    @(posedge CK_t); #1;
  endtask

  task automatic at_cycle(input int c);
    for (int k = 0; k < 70000; k++) begin
      @(negedge CK_t);
      if (cyc >= c) break;
    end
    check("at_cycle", cyc, c);
  endtask

  task automatic pulse_start(output int s);
    step(); refresh_start = 1'b1; s = cyc;
    step(); refresh_start = 1'b0;
  endtask

  task automatic do_clear();
    step(); clear_refresh = 1'b1;
    step(); clear_refresh = 1'b0;
  endtask

  int s, first_ref, last_ref, n_refs;

  initial begin
    reset_n = 1'b0; clear_refresh = 1'b0; refresh_start = 1'b0; cmd_ready = 1'b1;
    #23;
    check("reset_outs", {cmd_valid, cmd_is_ref, refresh_almost, refresh_done, refresh_err}, 5'b0);
    @(posedge CK_t); #1; reset_n = 1'b1;   // cycle 0 starts here

    // Idle: almost rises at 6177, one refresh owed from 6240.
    at_cycle(TREFI - ALMOST_WIN);
    check("almost_pre", refresh_almost, 1'b0);
    at_cycle(6177);
    check("almost_rise", refresh_almost, 1'b1);
    at_cycle(6239);
    check("pend_pre", dut.u_cnt.pending_q, 0);
    at_cycle(6240);
    check("pend_6240", dut.u_cnt.pending_q, 1);
    check("model_pend_6240", m_pending, 1);

    // Full sequence, ready tied high.
    pulse_start(s);
    at_cycle(s + 1);   check("prea", {cmd_valid, cmd_is_ref}, 2'b10);
    at_cycle(s + 12);  check("trp_quiet", cmd_valid, 1'b0);
    at_cycle(s + 13);  check("ref", {cmd_valid, cmd_is_ref}, 2'b11);
    at_cycle(s + 15);  check("almost_fall", refresh_almost, 1'b0);
    at_cycle(s + 293); check("done_pre", refresh_done, 1'b0);
    at_cycle(s + 294); check("done_rise", refresh_done, 1'b1);
    at_cycle(s + 320); check("done_held", refresh_done, 1'b1);
    do_clear();
    at_cycle(cyc);     check("done_clear", refresh_done, 1'b0);

    // Backpressure on PREA for 5 cycles; REF shifts by 5.
    cmd_ready = 1'b0;
    pulse_start(s);
    for (int k = 1; k <= 5; k++) begin
      at_cycle(s + k); check("bp_hold", {cmd_valid, cmd_is_ref}, 2'b10);
    end
    step(); cmd_ready = 1'b1;
    at_cycle(s + 17); check("bp_trp", cmd_valid, 1'b0);
    at_cycle(s + 18); check("bp_ref", {cmd_valid, cmd_is_ref}, 2'b11);
    at_cycle(s + 299); check("bp_done", refresh_done, 1'b1);
    do_clear();

    // Pulled-in REF at icnt 6200 with nothing owed.
    for (int k = 0; k < 8000; k++) begin
      step();
      if (m_icnt == 6187) break;
    end
    check("pull_wait", m_icnt, 6187);
    refresh_start = 1'b1; s = cyc;
    step(); refresh_start = 1'b0;
    at_cycle(s + 13);
    check("pull_icnt_pre", dut.u_cnt.icnt_q, 6200);
    at_cycle(s + 14);
    check("pull_icnt", dut.u_cnt.icnt_q, 0);
    check("pull_pend", dut.u_cnt.pending_q, 0);
    check("pull_err", refresh_err, 1'b0);
    at_cycle(s + 294);
    do_clear();

    // Randomized traffic, checked by the continuous compare.
    for (int k = 0; k < 8000; k++) begin
      step();
      cmd_ready     = ($urandom_range(0, 3) != 0);
      refresh_start = ($urandom_range(0, 7) == 0);
      clear_refresh = m_done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
    end
    step(); refresh_start = 1'b0; cmd_ready = 1'b1; clear_refresh = 1'b1;
    step(); clear_refresh = 1'b0;

    // Reset in the middle of tRFC.
    pulse_start(s);
    at_cycle(s + 73);
    step();
    reset_n = 1'b0;
    #1;
    check("rst_async", {cmd_valid, cmd_is_ref, refresh_almost, refresh_done, refresh_err}, 5'b0);
    repeat (2) @(posedge CK_t);
    #1; reset_n = 1'b1;
    at_cycle(3);
    check("rst_state", dut.state_q, RF_IDLE);
    check("rst_valid", cmd_valid, 1'b0);

    // Debt overflow: error on wrap number MAX_DEBT+1.
    at_cycle((MAX_DEBT + 1) * TREFI - 1);
    check("ovf_pre", refresh_err, 1'b0);
    at_cycle((MAX_DEBT + 1) * TREFI);
    check("ovf_err", refresh_err, 1'b1);
    check("ovf_pend", dut.u_cnt.pending_q, MAX_DEBT);

    // Next sequence issues MAX_DEBT REFs spaced by TRFC+1.
    pulse_start(s);
    n_refs = 0; first_ref = -1; last_ref = -1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge CK_t);
      if (refresh_done) break;
      if (cmd_valid && cmd_is_ref && cmd_ready) begin
        if (first_ref < 0) first_ref = cyc;
        else check("ref_gap", cyc - last_ref, TRFC + 1);
        last_ref = cyc;
        n_refs++;
      end
    end
    check("drain_done", refresh_done, 1'b1);
    check("first_ref", first_ref - s, 13);
    check("ref_count", n_refs, MAX_DEBT);
    check("err_sticky", refresh_err, 1'b1);
    do_clear();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
